// File: rtl/gdb_rsp_pkg.sv
// Shared byte constants, decoder states and hex helper for the GDB RSP receive path.
package gdb_rsp_pkg;

    localparam logic [7:0] RSP_SOP     = 8'h24;
    localparam logic [7:0] RSP_EOP     = 8'h23;
    localparam logic [7:0] RSP_ESC     = 8'h7D;
    localparam logic [7:0] RSP_ESC_XOR = 8'h20;
    localparam logic [7:0] RSP_ACK     = 8'h2B;
    localparam logic [7:0] RSP_NAK     = 8'h2D;
    localparam logic [7:0] RSP_BRK     = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        ESC,
        CS_HI,
        CS_LO,
        ACK,
        OUT
    } rsp_state_t;

    // Returns {valid, nibble}; valid is 0 for anything outside 0-9, a-f, A-F.
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'h00;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

endpackage

// File: rtl/gdb_rsp_buf.sv
// Payload store for one unescaped packet: one write port, asynchronous read port.
module gdb_rsp_buf #(
    parameter int MAX_LEN = 256,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdat,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdat
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdat;
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/gdb_rsp_rx.sv
// GDB RSP receive decoder: frames $payload#hh, unescapes, verifies checksum, acks and
// releases verified payloads.
//
// state | meaning
// IDLE  | waiting for '$'; 0x03 raises brk, other bytes dropped
// DATA  | collecting payload bytes into the buffer
// ESC   | next byte is escaped (xor 0x20)
// CS_HI | high checksum digit
// CS_LO | low checksum digit, verdict computed
// ACK   | presenting '+' or '-' to the send path
// OUT   | streaming the verified payload
module gdb_rsp_rx
    import gdb_rsp_pkg::*;
#(
    parameter int MAX_LEN = 256,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_vld,
    input  logic [7:0]    rx_dat,
    output logic          rx_rdy,
    output logic          ack_vld,
    output logic [7:0]    ack_dat,
    input  logic          ack_rdy,
    output logic          pkt_vld,
    output logic [7:0]    pkt_dat,
    output logic          pkt_lst,
    output logic [LW-1:0] pkt_len,
    input  logic          pkt_rdy,
    output logic          brk,
    output logic          err_csum,
    output logic          err_ovf
);

    localparam int AW = $clog2(MAX_LEN);

    rsp_state_t    state, state_nxt;
    logic [7:0]    sum;
    logic [LW-1:0] len, rd;
    logic          ovf, bad, ok;
    logic [3:0]    hi_nib;
    logic          acc, store, full, csum_ok;
    logic [4:0]    hexv;
    logic [7:0]    wdat, rdat;

    assign acc     = rx_vld && rx_rdy;
    assign full    = (len == LW'(MAX_LEN));
    assign hexv    = hex2nib(rx_dat);
    assign csum_ok = !bad && hexv[4] && !ovf && ({hi_nib, hexv[3:0]} == sum);
    assign wdat    = (state == ESC) ? (rx_dat ^ RSP_ESC_XOR) : rx_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        store     = 1'b0;
        case (state)
            IDLE:  if (acc && rx_dat == RSP_SOP) state_nxt = DATA;
            DATA: begin
                if (acc) begin
                    if (rx_dat == RSP_EOP)      state_nxt = CS_HI;
                    else if (rx_dat == RSP_ESC) state_nxt = ESC;
                    else if (rx_dat != RSP_SOP) store = 1'b1;
                end
            end
            ESC: begin
                if (acc) begin
                    store     = 1'b1;
                    state_nxt = DATA;
                end
            end
            CS_HI: if (acc) state_nxt = CS_LO;
            CS_LO: if (acc) state_nxt = ACK;
            ACK:   if (ack_rdy) state_nxt = (ok && len != '0) ? OUT : IDLE;
            OUT:   if (pkt_rdy && pkt_lst) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            len      <= '0;
            rd       <= '0;
            ovf      <= 1'b0;
            bad      <= 1'b0;
            ok       <= 1'b0;
            hi_nib   <= '0;
            brk      <= 1'b0;
            err_csum <= 1'b0;
            err_ovf  <= 1'b0;
            ack_dat  <= RSP_ACK;
        end else begin
            brk      <= 1'b0;
            err_csum <= 1'b0;
            err_ovf  <= 1'b0;
            if (store) begin
                if (full) ovf <= 1'b1;
                else      len <= len + LW'(1);
            end
            case (state)
                IDLE: begin
                    if (acc && rx_dat == RSP_SOP) begin
                        sum <= '0;
                        len <= '0;
                        ovf <= 1'b0;
                        bad <= 1'b0;
                    end else if (acc && rx_dat == RSP_BRK) begin
                        brk <= 1'b1;
                    end
                end
                DATA: begin
                    // '$' inside a packet restarts framing on the new packet
                    if (acc && rx_dat == RSP_SOP) begin
                        sum <= '0;
                        len <= '0;
                        ovf <= 1'b0;
                        bad <= 1'b0;
                    end else if (acc && rx_dat != RSP_EOP) begin
                        sum <= sum + rx_dat;
                    end
                end
                ESC: if (acc) sum <= sum + rx_dat;
                CS_HI: begin
                    if (acc) begin
                        hi_nib <= hexv[3:0];
                        if (!hexv[4]) bad <= 1'b1;
                    end
                end
                CS_LO: begin
                    if (acc) begin
                        ok       <= csum_ok;
                        ack_dat  <= csum_ok ? RSP_ACK : RSP_NAK;
                        err_csum <= !csum_ok && !ovf;
                        err_ovf  <= ovf;
                        rd       <= '0;
                    end
                end
                OUT: if (pkt_rdy) rd <= rd + LW'(1);
                default: ;
            endcase
        end
    end

    gdb_rsp_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (store && !full),
        .waddr (len[AW-1:0]),
        .wdat  (wdat),
        .raddr (rd[AW-1:0]),
        .rdat  (rdat)
    );

    assign rx_rdy  = !rst && (state != ACK) && (state != OUT);
    assign ack_vld = (state == ACK);
    assign pkt_vld = (state == OUT);
    assign pkt_dat = pkt_vld ? rdat : 8'h00;
    assign pkt_lst = pkt_vld && (rd == len - LW'(1));
    assign pkt_len = pkt_vld ? len : '0;

endmodule

// File: tb/tb_gdb_rsp_rx.sv
// Directed bench for gdb_rsp_rx with a 4-byte buffer so overflow is easy to reach.
module tb_gdb_rsp_rx;

    localparam int MAX_LEN = 4;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk, rst;
    logic          rx_vld, rx_rdy, ack_vld, ack_rdy;
    logic [7:0]    rx_dat, ack_dat, pkt_dat;
    logic          pkt_vld, pkt_lst, pkt_rdy, brk, err_csum, err_ovf;
    logic [LW-1:0] pkt_len;

    int errors  = 0;
    int checks  = 0;
    int brk_cnt = 0;

    gdb_rsp_rx #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst),
        .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_rdy(rx_rdy),
        .ack_vld(ack_vld), .ack_dat(ack_dat), .ack_rdy(ack_rdy),
        .pkt_vld(pkt_vld), .pkt_dat(pkt_dat), .pkt_lst(pkt_lst),
        .pkt_len(pkt_len), .pkt_rdy(pkt_rdy),
        .brk(brk), .err_csum(err_csum), .err_ovf(err_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (brk) brk_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got    = 1'b0;
        rx_vld = 1'b1;
        rx_dat = b;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (rx_rdy) got = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_vld = 1'b0;
        check("rx_accept", 32'(got), 32'd1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic run_pkt(input string pkt, input string beats, input logic [7:0] ack,
                           input logic ecs, input logic eov, input logic toggle, input int stall);
        int   n;
        logic done;
        send_str(pkt);
        check("ack_vld", 32'(ack_vld), 32'd1);
        check("ack_dat", 32'(ack_dat), 32'(ack));
        check("err_csum", 32'(err_csum), 32'(ecs));
        check("err_ovf", 32'(err_ovf), 32'(eov));
        for (int c = 0; c < stall; c++) begin
            @(posedge clk);
            #1;
            check("stall_rx_rdy", 32'(rx_rdy), 32'd0);
            check("stall_ack_vld", 32'(ack_vld), 32'd1);
            check("stall_ack_dat", 32'(ack_dat), 32'(ack));
        end
        ack_rdy = 1'b1;
        @(posedge clk);
        #1;
        ack_rdy = 1'b0;
        check("ack_dropped", 32'(ack_vld), 32'd0);
        n    = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            pkt_rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (pkt_vld) begin
                if (n < beats.len()) begin
                    check("beat_dat", 32'(pkt_dat), 32'(beats[n]));
                    check("beat_lst", 32'(pkt_lst), 32'(n == beats.len() - 1));
                    check("beat_len", 32'(pkt_len), 32'(beats.len()));
                end
                if (pkt_rdy) begin
                    n++;
                    if (pkt_lst) done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        pkt_rdy = 1'b0;
        check("beat_count", 32'(n), 32'(beats.len()));
        check("back_idle", 32'(rx_rdy), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_rdy", 32'(rx_rdy), 32'd0);
        check("rst_ack_vld", 32'(ack_vld), 32'd0);
        check("rst_ack_dat", 32'(ack_dat), 32'h2B);
        check("rst_pkt_vld", 32'(pkt_vld), 32'd0);
        check("rst_pkt_lst", 32'(pkt_lst), 32'd0);
        check("rst_pkt_dat", 32'(pkt_dat), 32'd0);
        check("rst_pkt_len", 32'(pkt_len), 32'd0);
        check("rst_brk", 32'(brk), 32'd0);
        check("rst_err_csum", 32'(err_csum), 32'd0);
        check("rst_err_ovf", 32'(err_ovf), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        rx_vld  = 1'b0;
        rx_dat  = 8'h00;
        ack_rdy = 1'b0;
        pkt_rdy = 1'b0;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_rx_rdy", 32'(rx_rdy), 32'd1);

        run_pkt("$g#67", "g", 8'h2B, 1'b0, 1'b0, 1'b0, 0);
        run_pkt("$m0,4#fd", "m0,4", 8'h2B, 1'b0, 1'b0, 1'b0, 0);
        run_pkt("$m0,4#fd", "m0,4", 8'h2B, 1'b0, 1'b0, 1'b1, 0);
        run_pkt("$}]#da", "}", 8'h2B, 1'b0, 1'b0, 1'b0, 0);
        run_pkt("$g#68", "", 8'h2D, 1'b1, 1'b0, 1'b0, 0);
        run_pkt("$g#6z", "", 8'h2D, 1'b1, 1'b0, 1'b0, 0);
        run_pkt("$abcde#ef", "", 8'h2D, 1'b0, 1'b1, 1'b0, 0);
        run_pkt("$g#67", "g", 8'h2B, 1'b0, 1'b0, 1'b0, 0);

        send_byte(8'h2B);
        send_byte(8'h03);
        check("brk_pulse", 32'(brk), 32'd1);
        send_byte(8'h2D);
        run_pkt("$ab$g#67", "g", 8'h2B, 1'b0, 1'b0, 1'b0, 0);
        check("brk_count", 32'(brk_cnt), 32'd1);
        run_pkt("$#00", "", 8'h2B, 1'b0, 1'b0, 1'b0, 0);

        send_str("$ab");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_pkt("$g#67", "g", 8'h2B, 1'b0, 1'b0, 1'b0, 0);

        run_pkt("$g#67", "g", 8'h2B, 1'b0, 1'b0, 1'b0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gdb_rsp_rx.md
Name: gdb_rsp_rx

Overview:
- Receive-side GDB Remote Serial Protocol (RSP) packet decoder for the simulation GDB stub.
- Consumes the raw byte stream that the socket DPI layer returns from the debugger.
- Frames packets of the form `$payload#hh`, removes escapes, and checks the modulo-256 checksum.
- Generates the `+`/`-` acknowledge byte for the send path and releases only checksum-verified payloads to the command handler.

Parameters:
- MAX_LEN, 256, payload buffer depth in bytes after unescaping; must be ≥2.
- LW, $clog2(MAX_LEN+1), width of the length counter and of `pkt_len`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_vld  in  1  input byte valid.
- rx_dat  in  8  input byte from the socket.
- rx_rdy  out  1  input byte accepted when rx_vld&&rx_rdy.
- ack_vld  out  1  acknowledge byte valid.
- ack_dat  out  8  acknowledge byte: 0x2B (`+`) or 0x2D (`-`).
- ack_rdy  in  1  send path accepts the acknowledge byte.
- pkt_vld  out  1  payload beat valid.
- pkt_dat  out  8  payload byte, already unescaped.
- pkt_lst  out  1  last payload beat.
- pkt_len  out  LW  payload length, stable while pkt_vld.
- pkt_rdy  in  1  downstream accepts the beat.
- brk  out  1  one-cycle pulse when 0x03 (Ctrl-C) is seen outside a packet.
- err_csum  out  1  one-cycle pulse on a checksum mismatch or a non-hex checksum digit.
- err_ovf  out  1  one-cycle pulse when a packet was dropped for exceeding MAX_LEN.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - rx_rdy=0 during reset, 1 in IDLE afterwards.
  - All other outputs (ack_vld, pkt_vld, pkt_lst, brk, err_*) =0; ack_dat=0x2B; pkt_len=0; pkt_dat=0.
  - Counters and checksum are cleared; buffer contents are don't-care.
  - Reset mid-packet discards the packet silently.
- States: IDLE, DATA, ESC, CS_HI, CS_LO, ACK, OUT.
- rx_rdy is 1 in IDLE/DATA/ESC/CS_HI/CS_LO and 0 in ACK/OUT. A single buffer is used, so there is no overlap between packets.
- IDLE:
  - `$` → DATA; clear sum, len and ovf.
  - 0x03 → brk pulses in the following cycle; stay in IDLE.
  - All other bytes (`+`, `-`, noise) are discarded.
- DATA:
  - Every accepted byte except the opening `$` and the `#` adds to sum (8-bit wrap). This includes `}` and the raw escaped byte.
  - `#` → CS_HI.
  - `$` → resync: restart as a new packet, clearing sum, len and ovf.
  - `}` → ESC.
  - Any other byte is written to buf[len], then len++.
  - A write when len==MAX_LEN sets ovf and drops the byte; the bytes that follow are still summed.
- ESC: the byte is added to sum; (byte ^ 0x20) is stored like a normal DATA byte; → DATA.
- CS_HI / CS_LO:
  - Accept hex digits 0-9, a-f, A-F.
  - A non-hex digit sets a bad flag; the state advances anyway.
  - After CS_LO: ok = !bad && !ovf && (digits == sum).
  - → ACK with ack_dat = ok ? `+` : `-`.
  - err_csum pulses for !ok && !ovf; err_ovf pulses for ovf. Both pulse in the cycle ACK is entered.
- ACK:
  - ack_vld=1 until the ack_vld&&ack_rdy handshake.
  - Then → OUT if ok && len>0, else → IDLE.
  - ok && len==0 (`$#00`) is acked with `+` and emits no beats.
- OUT:
  - pkt_vld=1, pkt_dat=buf[rd], pkt_lst=(rd==len-1), pkt_len=len.
  - rd++ on handshake; the lst handshake → IDLE.
  - pkt_dat and pkt_lst must hold while pkt_vld && !pkt_rdy.
- Throughput: one input byte per cycle. The ack is available one cycle after the second checksum digit is accepted; the first payload beat follows one cycle after the ack handshake.

Decomposition:
- Shared package gdb_rsp_pkg holds:
  - byte constants RSP_SOP=0x24, RSP_EOP=0x23, RSP_ESC=0x7D, RSP_ESC_XOR=0x20, RSP_ACK=0x2B, RSP_NAK=0x2D, RSP_BRK=0x03;
  - the state enum;
  - function hex2nib (returns the nibble plus a valid bit).
- One natural sub-module, gdb_rsp_buf: MAX_LEN×8 register array with a write port and an asynchronous read port.

Test Plan:
- `$g#67` → ack `+`; one beat 0x67 with pkt_lst=1 and pkt_len=1; no err pulses.
- `$m0,4#fd` → ack `+`; beats 6D 30 2C 34 with lst on the 4th beat and pkt_len=4. Repeat with pkt_rdy toggling 1/0 every cycle: beats must be unchanged and none lost.
- `$}]#da` → ack `+`; one beat 0x7D. `$g#68` → ack `-`, err_csum=1, no beats. `$g#6z` → ack `-`, err_csum=1.
- MAX_LEN=4: `$abcde#ef` → ack `-`, err_ovf=1, err_csum=0, no beats; a following `$g#67` is decoded correctly.
- Bytes `+`, 0x03, `-`, then `$ab$g#67` → exactly one brk pulse; `ab` is discarded by the resync; one beat 0x67 is acked `+`. `$#00` → ack `+`, no beats.
- Assert rst after `$ab`, then send `$g#67` → all outputs are at reset values during reset; afterwards one beat 0x67 is acked `+`. Hold ack_rdy=0 for 5 cycles → rx_rdy=0 and ack_vld held for the whole stall.
